// File: rtl/mdu_seq_pkg.sv
// Shared MDU decode: funct3 op encodings, FSM states and latched-op record.
// Pure declarations; no timing. Imported by the ALU/MDU decode and the MDU datapath.
package mdu_seq_pkg;

  localparam int HXLEN = 32;

  localparam logic [2:0] MDU_OP_MUL    = 3'b000;
  localparam logic [2:0] MDU_OP_MULH   = 3'b001;
  localparam logic [2:0] MDU_OP_MULHSU = 3'b010;
  localparam logic [2:0] MDU_OP_MULHU  = 3'b011;
  localparam logic [2:0] MDU_OP_DIV    = 3'b100;
  localparam logic [2:0] MDU_OP_DIVU   = 3'b101;
  localparam logic [2:0] MDU_OP_REM    = 3'b110;
  localparam logic [2:0] MDU_OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mdu_state_e;

  typedef struct packed {
    logic [2:0] funct3;
    logic       is_w;
    logic       sa;
    logic       sb;
  } mdu_op_t;

  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == MDU_OP_MUL) || (f3 == MDU_OP_MULH) || (f3 == MDU_OP_MULHSU) ||
           (f3 == MDU_OP_DIV) || (f3 == MDU_OP_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == MDU_OP_MUL) || (f3 == MDU_OP_MULH) ||
           (f3 == MDU_OP_DIV) || (f3 == MDU_OP_REM);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring divider: holds partial remainder/quotient, one quotient bit per step.
// quo_nxt/rem_nxt are the combinational results of the current step; no backpressure.
module mdu_divider
  import mdu_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_w,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_nxt,
  output logic [XLEN-1:0] rem_nxt
);

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dsr_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dsr_q};
    if (shifted >= {1'b0, dsr_q}) begin
      rem_nxt = trial[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  // W dividends are left-aligned so the first 32 steps shift in their bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else if (load) begin
      quo_q <= is_w ? (dividend << HXLEN) : dividend;
      rem_q <= '0;
      dsr_q <= divisor;
    end else if (step) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV64M/RV32M multiply/divide; N cycles busy (N=32 for W ops), special cases done next cycle.
// in_ready only in IDLE; result held until out_ready. MDU_FAST_MUL_EN selects a single-cycle multiply.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      mdu_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam int PW = 2 * XLEN;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    return XLEN'(signed'(v[HXLEN-1:0]));
  endfunction

  function automatic logic [XLEN-1:0] mul_result(input logic [PW-1:0] prod, input logic neg,
                                                 input logic [2:0] f3, input logic w);
    logic [PW-1:0] fix;
    fix = neg ? -prod : prod;
    if (f3 == MDU_OP_MUL) return w ? sext_w(fix[XLEN-1:0]) : fix[XLEN-1:0];
    return fix[PW-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] div_result(input logic [XLEN-1:0] quo, input logic [XLEN-1:0] rem,
                                                 input logic sa, input logic sb,
                                                 input logic [2:0] f3, input logic w);
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] v;
    q = (sa ^ sb) ? -quo : quo;
    r = sa ? -rem : rem;
    v = f3[1] ? r : q;
    return w ? sext_w(v) : v;
  endfunction

  mdu_state_e      state_q, state_d;
  logic            accept;
  logic [CW-1:0]   cnt_q;
  mdu_op_t         op_q, op_in;
  logic [PW-1:0]   prod_q, mcand_q, prod_nxt;
  logic [XLEN-1:0] mplier_q, result_q;
  logic [XLEN-1:0] quo_nxt, rem_nxt;

  logic [2:0]      f3;
  logic            in_w, a_sgn, b_sgn, sa_in, sb_in;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_n, div_dvd;
  logic            div_zero, div_ovf, w_mulh, fast_mul, special;
  logic [XLEN-1:0] special_res;

  // Operand preparation and special-case detection on the incoming request.
  always_comb begin
    f3    = mdu_ctrl[2:0];
    in_w  = (XLEN == 64) && mdu_ctrl[4];
    a_sgn = a_is_signed(f3);
    b_sgn = b_is_signed(f3);
    a_ext = a;
    b_ext = b;
    if (in_w) begin
      a_ext = a_sgn ? sext_w(a) : XLEN'(a[HXLEN-1:0]);
      b_ext = b_sgn ? sext_w(b) : XLEN'(b[HXLEN-1:0]);
    end
    sa_in = a_sgn & a_ext[XLEN-1];
    sb_in = b_sgn & b_ext[XLEN-1];
    a_mag = sa_in ? -a_ext : a_ext;
    b_mag = sb_in ? -b_ext : b_ext;
    min_n = in_w ? sext_w(XLEN'(1) << (HXLEN - 1)) : (XLEN'(1) << (XLEN - 1));

    div_zero = f3[2] && (b_ext == '0);
    div_ovf  = f3[2] && !f3[0] && (a_ext == min_n) && (b_ext == '1);
    w_mulh   = in_w && !f3[2] && (f3[1:0] != 2'b00);
`ifdef MDU_FAST_MUL_EN
    fast_mul = !f3[2];
`else
    fast_mul = 1'b0;
`endif
    special = div_zero | div_ovf | w_mulh | fast_mul;
    div_dvd = in_w ? sext_w(a) : a;

    special_res = '0;
    if (w_mulh)        special_res = '0;
    else if (fast_mul) special_res = mul_result(PW'(a_mag) * PW'(b_mag), sa_in ^ sb_in, f3, in_w);
    else if (div_zero) special_res = f3[1] ? div_dvd : '1;
    else if (div_ovf)  special_res = f3[1] ? '0 : div_dvd;

    op_in = '{funct3: f3, is_w: in_w, sa: sa_in, sb: sb_in};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == ST_IDLE) && !rst;
    out_valid = (state_q == ST_DONE);
    accept    = in_valid && in_ready && !flush;
    case (state_q)
      ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_BUSY;
      ST_BUSY: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);

  mdu_divider #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && f3[2]),
    .step     ((state_q == ST_BUSY) && op_q.funct3[2] && !flush),
    .is_w     (in_w),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

  // Final BUSY cycle writes the sign-fixed, W-extended result directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q     <= op_in;
      cnt_q    <= in_w ? CW'(HXLEN - 1) : CW'(XLEN - 1);
      prod_q   <= '0;
      mcand_q  <= PW'(a_mag);
      mplier_q <= b_mag;
      if (special) result_q <= special_res;
    end else if ((state_q == ST_BUSY) && !flush) begin
      cnt_q <= cnt_q - CW'(1);
      if (!op_q.funct3[2]) begin
        prod_q   <= prod_nxt;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
      if (cnt_q == '0) begin
        result_q <= op_q.funct3[2]
                    ? div_result(quo_nxt, rem_nxt, op_q.sa, op_q.sb, op_q.funct3, op_q.is_w)
                    : mul_result(prod_nxt, op_q.sa ^ op_q.sb, op_q.funct3, op_q.is_w);
      end
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: arithmetic results, latencies, special cases and control disruption.
module tb_mdu_seq;

  localparam logic [4:0] C_MUL    = 5'b00000;
  localparam logic [4:0] C_MULH   = 5'b00001;
  localparam logic [4:0] C_MULHSU = 5'b00010;
  localparam logic [4:0] C_MULHU  = 5'b00011;
  localparam logic [4:0] C_DIV    = 5'b00100;
  localparam logic [4:0] C_DIVU   = 5'b00101;
  localparam logic [4:0] C_REM    = 5'b00110;
  localparam logic [4:0] C_REMU   = 5'b00111;
  localparam logic [4:0] C_MULW   = 5'b10000;
  localparam logic [4:0] C_MULHW  = 5'b10001;
  localparam logic [4:0] C_DIVW   = 5'b10100;
  localparam logic [4:0] C_DIVUW  = 5'b10101;
  localparam logic [4:0] C_REMW   = 5'b10110;

`ifdef MDU_FAST_MUL_EN
  localparam int LAT_MUL  = 1;
  localparam int LAT_MULW = 1;
`else
  localparam int LAT_MUL  = 65;
  localparam int LAT_MULW = 33;
`endif

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  mdu_ctrl;
  logic [63:0] a, b, result;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  mdu_seq #(.XLEN(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mdu_ctrl  (mdu_ctrl),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Called at a negedge with the unit idle; lat counts cycles from accept (T+1 = 1).
  task automatic run_op(input logic [4:0] ctrl, input logic [63:0] op_a, input logic [63:0] op_b,
                        output logic [63:0] res, output int lat);
    mdu_ctrl = ctrl; a = op_a; b = op_b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    if (out_ready) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (result !== 64'h0) begin fails++; $display("FAIL reset_result got %h exp 0", result); end
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_mul();
    logic [63:0] r; int lat;
    run_op(C_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, r, lat);
    tests++; if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin fails++; $display("FAIL mul_res got %h exp ffffffffffffffeb", r); end
    tests++; if (lat !== LAT_MUL) begin fails++; $display("FAIL mul_lat got %0d exp %0d", lat, LAT_MUL); end
    run_op(C_MULW, 64'h0000_0000_7FFF_FFFF, 64'd2, r, lat);
    tests++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin fails++; $display("FAIL mulw_res got %h exp fffffffffffffffe", r); end
    tests++; if (lat !== LAT_MULW) begin fails++; $display("FAIL mulw_lat got %0d exp %0d", lat, LAT_MULW); end
    run_op(C_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, r, lat);
    tests++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL mulhsu_res got %h exp ffffffffffffffff", r); end
  endtask

  task automatic test_mulh();
    logic [63:0] r; int lat;
    run_op(C_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, r, lat);
    tests++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin fails++; $display("FAIL mulhu_res got %h exp fffffffffffffffe", r); end
    tests++; if (lat !== LAT_MUL) begin fails++; $display("FAIL mulhu_lat got %0d exp %0d", lat, LAT_MUL); end
    run_op(C_MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, r, lat);
    tests++; if (r !== 64'h0) begin fails++; $display("FAIL mulh_neg_res got %h exp 0", r); end
    run_op(C_MULHW, 64'h1234, 64'h5678, r, lat);
    tests++; if (r !== 64'h0) begin fails++; $display("FAIL mulhw_res got %h exp 0", r); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL mulhw_lat got %0d exp 1", lat); end
  endtask

  task automatic test_div();
    logic [63:0] r; int lat;
    run_op(C_DIVU, 64'd100, 64'd7, r, lat);
    tests++; if (r !== 64'd14) begin fails++; $display("FAIL divu_res got %h exp e", r); end
    tests++; if (lat !== 65) begin fails++; $display("FAIL divu_lat got %0d exp 65", lat); end
    run_op(C_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, r, lat);
    tests++; if (r !== 64'hFFFF_FFFF_FFFF_FFF2) begin fails++; $display("FAIL div_neg_res got %h exp fffffffffffffff2", r); end
    run_op(C_REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, r, lat);
    tests++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin fails++; $display("FAIL rem_neg_res got %h exp fffffffffffffffe", r); end
  endtask

  task automatic test_div_zero();
    logic [63:0] r; int lat;
    run_op(C_DIV, 64'd42, 64'd0, r, lat);
    tests++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL div0_res got %h exp ffffffffffffffff", r); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL div0_lat got %0d exp 1", lat); end
    run_op(C_REMU, 64'd42, 64'd0, r, lat);
    tests++; if (r !== 64'd42) begin fails++; $display("FAIL remu0_res got %h exp 2a", r); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL remu0_lat got %0d exp 1", lat); end
  endtask

  task automatic test_div_ovf();
    logic [63:0] r; int lat;
    run_op(C_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, lat);
    tests++; if (r !== 64'h8000_0000_0000_0000) begin fails++; $display("FAIL divovf_res got %h exp 8000000000000000", r); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL divovf_lat got %0d exp 1", lat); end
    run_op(C_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, lat);
    tests++; if (r !== 64'h0) begin fails++; $display("FAIL removf_res got %h exp 0", r); end
  endtask

  task automatic test_divw();
    logic [63:0] r; int lat;
    run_op(C_DIVW, 64'h0000_0001_FFFF_FFF9, 64'd2, r, lat);
    tests++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin fails++; $display("FAIL divw_res got %h exp fffffffffffffffd", r); end
    tests++; if (lat !== 33) begin fails++; $display("FAIL divw_lat got %0d exp 33", lat); end
    run_op(C_REMW, 64'h0000_0001_FFFF_FFF9, 64'd2, r, lat);
    tests++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL remw_res got %h exp ffffffffffffffff", r); end
    run_op(C_DIVUW, 64'hFFFF_FFFF_0000_0010, 64'd3, r, lat);
    tests++; if (r !== 64'd5) begin fails++; $display("FAIL divuw_res got %h exp 5", r); end
  endtask

  task automatic test_flush();
    bit seen;
    mdu_ctrl = C_DIVU; a = 64'd1000; b = 64'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL busy_in_ready got %b exp 0", in_ready); end
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_idle got in_ready %b exp 1", in_ready); end
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL flush_no_result got out_valid seen %b exp 0", seen); end
    flush = 1'b1; in_valid = 1'b1; mdu_ctrl = C_DIV; a = 64'd42; b = 64'd0;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_prio_out_valid got %b exp 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_prio_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_hold();
    logic [63:0] r; int lat; int bad;
    out_ready = 1'b0;
    run_op(C_DIVU, 64'd1000, 64'd10, r, lat);
    tests++; if (r !== 64'd100) begin fails++; $display("FAIL hold_res got %h exp 64", r); end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || result !== 64'd100) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL hold_stable got %0d unstable cycles exp 0", bad); end
    out_ready = 1'b1;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL hold_release got out_valid %b exp 0", out_valid); end
  endtask

  task automatic test_rst_busy();
    logic [63:0] r; int lat;
    mdu_ctrl = C_DIVU; a = 64'd100; b = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_busy_out_valid got %b exp 0", out_valid); end
    tests++; if (result !== 64'h0) begin fails++; $display("FAIL rst_busy_result got %h exp 0", result); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_busy_in_ready got %b exp 0", in_ready); end
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_busy_recover got in_ready %b exp 1", in_ready); end
    @(negedge clk);
    run_op(C_DIVU, 64'd100, 64'd7, r, lat);
    tests++; if (r !== 64'd14) begin fails++; $display("FAIL rst_busy_next got %h exp e", r); end
  endtask

  task automatic test_back_to_back();
    int t1; int t2; int guard; logic [63:0] r1;
    r1 = '0;
    mdu_ctrl = C_DIVU; a = 64'd81; b = 64'd9; in_valid = 1'b1;
    @(posedge clk);
    t1 = cyc;
    @(negedge clk);
    mdu_ctrl = C_REMU; a = 64'd81; b = 64'd10;
    guard = 0;
    while (!in_ready && guard < 200) begin
      if (out_valid) r1 = result;
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    t2 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (r1 !== 64'd9) begin fails++; $display("FAIL b2b_first got %h exp 9", r1); end
    tests++; if (t2 - t1 !== 66) begin fails++; $display("FAIL b2b_spacing got %0d exp 66", t2 - t1); end
    guard = 0;
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    tests++; if (result !== 64'd1) begin fails++; $display("FAIL b2b_second got %h exp 1", result); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mdu_ctrl = '0; a = '0; b = '0;
    test_reset();
    @(negedge clk);
    test_mul();
    test_mulh();
    test_div();
    test_div_zero();
    test_div_ovf();
    test_divw();
    test_flush();
    test_hold();
    test_rst_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
